alu_mdu: RTL

//   Parametrised execute unit for the single-/multi-cycle MIPS datapath. Merges the combinational ALU op set

---
 rtl/alu_pkg.sv | 55 +++++
 rtl/alu_core.sv | 40 ++++
 rtl/alu_mdu.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the MIPS execute unit: op codes, FSM encoding and
// small decode helpers used by alu_mdu and alu_core.
package alu_pkg;

    localparam logic [4:0] OP_AND   = 5'h00;
    localparam logic [4:0] OP_OR    = 5'h01;
    localparam logic [4:0] OP_ADD   = 5'h02;
    localparam logic [4:0] OP_ANDNA = 5'h03;
    localparam logic [4:0] OP_ANDNB = 5'h04;
    localparam logic [4:0] OP_PACK  = 5'h05;
    localparam logic [4:0] OP_SUB   = 5'h06;
    localparam logic [4:0] OP_EQ    = 5'h07;
    localparam logic [4:0] OP_SRL   = 5'h08;
    localparam logic [4:0] OP_SLT   = 5'h09;
    localparam logic [4:0] OP_SGT   = 5'h0A;
    localparam logic [4:0] OP_SLL   = 5'h0B;
    localparam logic [4:0] OP_SRA   = 5'h0C;
    localparam logic [4:0] OP_SLTU  = 5'h0D;
    localparam logic [4:0] OP_MULT  = 5'h10;
    localparam logic [4:0] OP_MULTU = 5'h11;
    localparam logic [4:0] OP_DIV   = 5'h12;
    localparam logic [4:0] OP_DIVU  = 5'h13;
    localparam logic [4:0] OP_MTHI  = 5'h14;
    localparam logic [4:0] OP_MTLO  = 5'h15;
    localparam logic [4:0] OP_MFHI  = 5'h16;
    localparam logic [4:0] OP_MFLO  = 5'h17;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2
    } state_t;

    function automatic logic is_alu_op(input logic [4:0] op);
        return op <= OP_SLTU;
    endfunction

    function automatic logic is_mul_op(input logic [4:0] op);
        return (op == OP_MULT) || (op == OP_MULTU);
    endfunction

    function automatic logic is_div_op(input logic [4:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    // Signed MULT/DIV have an even op code, the unsigned variants are odd.
    function automatic logic is_signed_op(input logic [4:0] op);
        return ~op[0];
    endfunction

    function automatic int max2(input int x, input int y);
        return (x > y) ? x : y;
    endfunction

endpackage

// File: rtl/alu_core.sv
// Purely combinational ALU op set (codes 0x00-0x0D). Shift amount comes from
// the low bits of A; compares yield a zero-extended 0/1.
module alu_core #(
    parameter int WIDTH = 32
) (
    input  logic [4:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y
);
    import alu_pkg::*;

    localparam int H  = WIDTH / 2;
    localparam int SW = $clog2(WIDTH);

    logic [SW-1:0] shamt;
    assign shamt = a[SW-1:0];

    always_comb begin
        y = '0;
        case (op)
            OP_AND:   y = a & b;
            OP_OR:    y = a | b;
            OP_ADD:   y = a + b;
            OP_ANDNA: y = ~a & b;
            OP_ANDNB: y = a & ~b;
            OP_PACK:  y = {b[H-1:0], a[H-1:0]};
            OP_SUB:   y = a - b;
            OP_EQ:    y = {{(WIDTH-1){1'b0}}, (a == b)};
            OP_SRL:   y = b >> shamt;
            OP_SLT:   y = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SGT:   y = {{(WIDTH-1){1'b0}}, ($signed(a) > $signed(b))};
            OP_SLL:   y = b << shamt;
            OP_SRA:   y = $unsigned($signed(b) >>> shamt);
            OP_SLTU:  y = {{(WIDTH-1){1'b0}}, (a < b)};
            default:  y = '0;
        endcase
    end

endmodule

// File: rtl/alu_mdu.sv
// Execute unit: registered ALU results, HI/LO moves and a fixed-latency
// MULT/DIV engine that stalls issue while an operation is in flight.
module alu_mdu #(
    parameter int WIDTH      = 32,
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic             out_valid,
    output logic [WIDTH-1:0] result,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    import alu_pkg::*;

    localparam int CNT_W = $clog2(max2(MUL_CYCLES, DIV_CYCLES) + 1);

    state_t             state_reg, state_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic [WIDTH-1:0]   a_reg, a_next, b_reg, b_next;
    logic               sgn_reg, sgn_next;
    logic [WIDTH-1:0]   hi_reg, hi_next, lo_reg, lo_next;
    logic [WIDTH-1:0]   result_reg, result_next;
    logic               valid_reg, valid_next;
    logic               accept;
    logic [WIDTH-1:0]   alu_y;

    assign in_ready  = (state_reg == ST_IDLE);
    assign busy      = (state_reg != ST_IDLE);
    assign accept    = in_valid && in_ready;
    assign out_valid = valid_reg;
    assign result    = result_reg;
    assign hi        = hi_reg;
    assign lo        = lo_reg;

    alu_core #(.WIDTH(WIDTH)) u_core (
        .op (op),
        .a  (src_a),
        .b  (src_b),
        .y  (alu_y)
    );

    // Multiply: extend to 2*WIDTH so a single truncated product covers both signednesses.
    logic [2*WIDTH-1:0] ext_a, ext_b, product;
    assign ext_a   = {{WIDTH{sgn_reg & a_reg[WIDTH-1]}}, a_reg};
    assign ext_b   = {{WIDTH{sgn_reg & b_reg[WIDTH-1]}}, b_reg};
    assign product = ext_a * ext_b;

    // Divide on magnitudes; MIN/-1 falls out naturally as quotient MIN, remainder 0.
    logic             neg_a, neg_b, div_zero;
    logic [WIDTH-1:0] mag_a, mag_b, div_b, mag_q, mag_r, quo, rem;
    assign neg_a    = sgn_reg & a_reg[WIDTH-1];
    assign neg_b    = sgn_reg & b_reg[WIDTH-1];
    assign div_zero = (b_reg == '0);
    assign mag_a    = neg_a ? -a_reg : a_reg;
    assign mag_b    = neg_b ? -b_reg : b_reg;
    assign div_b    = div_zero ? {{(WIDTH-1){1'b0}}, 1'b1} : mag_b;
    assign mag_q    = mag_a / div_b;
    assign mag_r    = mag_a % div_b;
    assign quo      = div_zero ? '1    : ((neg_a ^ neg_b) ? -mag_q : mag_q);
    assign rem      = div_zero ? a_reg : (neg_a ? -mag_r : mag_r);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (accept && is_mul_op(op)) begin
                    state_next = ST_MUL;
                end else if (accept && is_div_op(op)) begin
                    state_next = ST_DIV;
                end
            end
            ST_MUL, ST_DIV: begin
                if (cnt_reg == '0) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        cnt_next    = cnt_reg;
        a_next      = a_reg;
        b_next      = b_reg;
        sgn_next    = sgn_reg;
        hi_next     = hi_reg;
        lo_next     = lo_reg;
        result_next = result_reg;
        valid_next  = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (accept) begin
                    if (is_mul_op(op) || is_div_op(op)) begin
                        a_next   = src_a;
                        b_next   = src_b;
                        sgn_next = is_signed_op(op);
                        cnt_next = is_mul_op(op) ? CNT_W'(MUL_CYCLES - 1) : CNT_W'(DIV_CYCLES - 1);
                    end else begin
                        valid_next = 1'b1;
                        case (op)
                            OP_MTHI: begin
                                hi_next     = src_a;
                                result_next = src_a;
                            end
                            OP_MTLO: begin
                                lo_next     = src_a;
                                result_next = src_a;
                            end
                            OP_MFHI: result_next = hi_reg;
                            OP_MFLO: result_next = lo_reg;
                            default: result_next = is_alu_op(op) ? alu_y : '0;
                        endcase
                    end
                end
            end
            ST_MUL: begin
                if (cnt_reg == '0) begin
                    hi_next     = product[2*WIDTH-1:WIDTH];
                    lo_next     = product[WIDTH-1:0];
                    result_next = product[WIDTH-1:0];
                    valid_next  = 1'b1;
                end else begin
                    cnt_next = cnt_reg - CNT_W'(1);
                end
            end
            ST_DIV: begin
                if (cnt_reg == '0) begin
                    hi_next     = rem;
                    lo_next     = quo;
                    result_next = quo;
                    valid_next  = 1'b1;
                end else begin
                    cnt_next = cnt_reg - CNT_W'(1);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_reg    <= '0;
            a_reg      <= '0;
            b_reg      <= '0;
            sgn_reg    <= 1'b0;
            hi_reg     <= '0;
            lo_reg     <= '0;
            result_reg <= '0;
            valid_reg  <= 1'b0;
        end else begin
            cnt_reg    <= cnt_next;
            a_reg      <= a_next;
            b_reg      <= b_next;
            sgn_reg    <= sgn_next;
            hi_reg     <= hi_next;
            lo_reg     <= lo_next;
            result_reg <= result_next;
            valid_reg  <= valid_next;
        end
    end

endmodule
